// File: rtl/branch_predictor_unit.sv
// Dynamic branch predictor: PHT of saturating counters indexed bimodally or by gshare,
// with speculative global history, mispredict restore and saturating debug statistics.
module branch_predictor_unit #(
    parameter int ADDR_WIDTH = 16,
    parameter int INDEX_BITS = 4,
    parameter int CTR_BITS   = 2,
    parameter int GHR_BITS   = 4,
    parameter int MODE       = 0,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lookup_valid,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  prediction,
    output logic [INDEX_BITS-1:0] pred_index,
    output logic [CTR_BITS-1:0]   pred_state,
    output logic [GHR_BITS-1:0]   pred_ghr,
    input  logic                  update_valid,
    input  logic [INDEX_BITS-1:0] update_index,
    input  logic                  update_taken,
    input  logic                  update_mispredict,
    input  logic [GHR_BITS-1:0]   update_ghr,
    output logic [STAT_WIDTH-1:0] branch_count,
    output logic [STAT_WIDTH-1:0] miss_count
);

    localparam int unsigned ENTRIES = 2 ** INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};

    logic [CTR_BITS-1:0]   r_pht [ENTRIES];
    logic [GHR_BITS-1:0]   r_ghr;
    logic [STAT_WIDTH-1:0] r_branch_count;
    logic [STAT_WIDTH-1:0] r_miss_count;

    logic [INDEX_BITS-1:0] w_ghr_ext;
    logic [INDEX_BITS-1:0] w_lookup_idx;
    logic [CTR_BITS-1:0]   w_lookup_state;
    logic [CTR_BITS-1:0]   w_upd_cur;
    logic [CTR_BITS-1:0]   w_upd_next;
    logic [GHR_BITS-1:0]   w_ghr_next;

    generate
        if (ADDR_WIDTH > INDEX_BITS) begin : g_pc_high
            logic w_unused_pc_high;
            assign w_unused_pc_high = ^lookup_pc[ADDR_WIDTH-1:INDEX_BITS];
        end
    endgenerate

    assign w_ghr_ext = INDEX_BITS'(r_ghr);

    always_comb begin
        w_lookup_idx = lookup_pc[INDEX_BITS-1:0];
        if (MODE == 1) begin
            w_lookup_idx = lookup_pc[INDEX_BITS-1:0] ^ w_ghr_ext;
        end
        w_lookup_state = r_pht[w_lookup_idx];
    end

    assign prediction   = w_lookup_state[CTR_BITS-1];
    assign pred_index   = w_lookup_idx;
    assign pred_state   = w_lookup_state;
    assign pred_ghr     = r_ghr;
    assign branch_count = r_branch_count;
    assign miss_count   = r_miss_count;

    always_comb begin
        w_upd_cur  = r_pht[update_index];
        w_upd_next = w_upd_cur;
        if (update_taken && (w_upd_cur != '1)) begin
            w_upd_next = w_upd_cur + CTR_BITS'(1);
        end else if (!update_taken && (w_upd_cur != '0)) begin
            w_upd_next = w_upd_cur - CTR_BITS'(1);
        end
    end

    // Shift-left-and-insert form also covers a single-bit history register.
    always_comb begin
        w_ghr_next = r_ghr;
        if (MODE != 1) begin
            w_ghr_next = '0;
        end else if (update_valid && update_mispredict) begin
            w_ghr_next = (update_ghr << 1) | GHR_BITS'(update_taken);
        end else if (lookup_valid) begin
            w_ghr_next = (r_ghr << 1) | GHR_BITS'(prediction);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_pht[i] <= CTR_INIT;
            end
            r_ghr          <= '0;
            r_branch_count <= '0;
            r_miss_count   <= '0;
        end else begin
            if (update_valid) begin
                r_pht[update_index] <= w_upd_next;
                if (r_branch_count != '1) begin
                    r_branch_count <= r_branch_count + STAT_WIDTH'(1);
                end
                if (update_mispredict && (r_miss_count != '1)) begin
                    r_miss_count <= r_miss_count + STAT_WIDTH'(1);
                end
            end
            r_ghr <= w_ghr_next;
        end
    end

endmodule
